// File: rtl/clk_enable_bank.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// tick every active+1 cycles and a square wave that toggles on each tick.
module clk_enable_bank #(
    parameter int               CHANNELS    = 4,
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = {CNT_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sync_clear,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] div_value,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       pending
);

    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CNT_W-1:0]    active_q [CHANNELS];
    logic [CNT_W-1:0]    active_d [CHANNELS];
    logic [CNT_W-1:0]    shadow_q [CHANNELS];
    logic [CNT_W-1:0]    shadow_d [CHANNELS];
    logic [CNT_W-1:0]    slice_s  [CHANNELS];
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] pending_q, pending_d;

    // Unpack the per-channel divide values.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            slice_s[i] = div_value[i*CNT_W +: CNT_W];
        end
    end

    // Per-channel next-state: clear, count/wrap with shadow commit, or hold while disabled.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]     = cnt_q[i];
            active_d[i]  = active_q[i];
            shadow_d[i]  = shadow_q[i];
            tick_d[i]    = 1'b0;
            clk_out_d[i] = clk_out_q[i];
            pending_d[i] = pending_q[i];
            if (sync_clear) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                pending_d[i] = 1'b0;
                if (load[i]) begin
                    active_d[i] = slice_s[i];
                    shadow_d[i] = slice_s[i];
                end else if (pending_q[i]) begin
                    active_d[i] = shadow_q[i];
                end else begin
                    active_d[i] = active_q[i];
                end
            end else if (enable[i]) begin
                // The wrap compares against the old active value; a shadow commit only
                // takes effect for the following period, so no period is ever cut short.
                if (cnt_q[i] == active_q[i]) begin
                    cnt_d[i]     = '0;
                    tick_d[i]    = 1'b1;
                    clk_out_d[i] = ~clk_out_q[i];
                    if (pending_q[i]) begin
                        active_d[i]  = shadow_q[i];
                        pending_d[i] = 1'b0;
                    end else begin
                        active_d[i]  = active_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (load[i]) begin
                    shadow_d[i]  = slice_s[i];
                    pending_d[i] = 1'b1;
                end else begin
                    shadow_d[i]  = shadow_q[i];
                end
            end else begin
                if (load[i]) begin
                    active_d[i]  = slice_s[i];
                    shadow_d[i]  = slice_s[i];
                    cnt_d[i]     = '0;
                    pending_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                active_q[i] <= DEFAULT_DIV;
                shadow_q[i] <= DEFAULT_DIV;
            end
            tick_q    <= '0;
            clk_out_q <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            pending_q <= pending_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clk_enable_bank.sv
// Self-checking bench for clk_enable_bank: vector table, directed corner sequences and
// randomized traffic compared against a behavioural model.
module tb_clk_enable_bank;

    localparam int CH    = 4;
    localparam int W     = 8;    // narrow counter so the default ratio wraps in a short run
    localparam int DEF   = 255;
    localparam int LIMIT = 600;

    logic              clk = 1'b0;
    logic              reset;
    logic              sync_clear;
    logic [CH-1:0]     enable;
    logic [CH-1:0]     load;
    logic [CH*W-1:0]   div_value;
    logic [CH-1:0]     tick;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     pending;

    clk_enable_bank #(.CHANNELS(CH), .CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_clear (sync_clear),
        .enable     (enable),
        .load       (load),
        .div_value  (div_value),
        .tick       (tick),
        .clk_out    (clk_out),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt [CH];
    int m_act [CH];
    int m_shd [CH];
    int m_pnd [CH];
    int m_co  [CH];
    int m_tk  [CH];

    typedef struct {
        logic          sc;
        logic [CH-1:0] en;
        logic [CH-1:0] ld;
        logic [31:0]   dv;
        logic [CH-1:0] t;
        logic [CH-1:0] c;
        logic [CH-1:0] p;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] divs(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_act[i] = DEF; m_shd[i] = DEF;
            m_pnd[i] = 0; m_co[i] = 0;    m_tk[i] = 0;
        end
    endtask

    // One clock edge of the channel behaviour, applied to the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            int sl;
            sl = int'(div_value[i*W +: W]);
            m_tk[i] = 0;
            if (sync_clear) begin
                m_cnt[i] = 0; m_co[i] = 0;
                if (load[i]) begin
                    m_act[i] = sl; m_shd[i] = sl;
                end else if (m_pnd[i] != 0) begin
                    m_act[i] = m_shd[i];
                end
                m_pnd[i] = 0;
            end else if (enable[i]) begin
                if (m_cnt[i] == m_act[i]) begin
                    m_cnt[i] = 0; m_tk[i] = 1; m_co[i] = 1 - m_co[i];
                    if (m_pnd[i] != 0) begin
                        m_act[i] = m_shd[i]; m_pnd[i] = 0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                if (load[i]) begin
                    m_shd[i] = sl; m_pnd[i] = 1;
                end
            end else if (load[i]) begin
                m_act[i] = sl; m_shd[i] = sl; m_cnt[i] = 0; m_pnd[i] = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [CH-1:0] et, ec, ep;
        for (int i = 0; i < CH; i++) begin
            et[i] = (m_tk[i] != 0);
            ec[i] = (m_co[i] != 0);
            ep[i] = (m_pnd[i] != 0);
        end
        check("model tick", 32'(tick), 32'(et));
        check("model clk_out", 32'(clk_out), 32'(ec));
        check("model pending", 32'(pending), 32'(ep));
    endtask

    task automatic step(input logic s, input logic [CH-1:0] e, input logic [CH-1:0] l,
                        input logic [31:0] d);
        sync_clear = s; enable = e; load = l; div_value = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Edges until tick[ch] is seen (first edge counts as 1); -1 if it never comes.
    task automatic wait_tick(input int ch, input logic [CH-1:0] e, output int n);
        n = -1;
        for (int k = 1; k <= LIMIT; k++) begin
            step(1'b0, e, 4'h0, 32'h0);
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic held;

        tbl[0]  = '{1'b1, 4'hF, 4'hF, divs(0, 1, 3, 9), 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0001, 4'b0001, 4'b0000};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0011, 4'b0010, 4'b0000};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0001, 4'b0011, 4'b0000};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0111, 4'b0100, 4'b0000};
        tbl[5]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0001, 4'b0101, 4'b0000};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0011, 4'b0110, 4'b0000};
        tbl[7]  = '{1'b0, 4'hF, 4'b0100, divs(0, 0, 7, 0), 4'b0001, 4'b0111, 4'b0100};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0111, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b0001, 4'b0001, 4'b0000};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 32'h0,            4'b1011, 4'b1010, 4'b0000};

        // Reset state
        reset = 1'b1; sync_clear = 1'b0; enable = 4'h0; load = 4'h0; div_value = 32'h0;
        model_reset();
        #12;
        check("reset tick", 32'(tick), 32'h0);
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset pending", 32'(pending), 32'h0);
        #10 reset = 1'b0;

        // Default ratio: tick after edges 256 and 512, clk_out rises then falls
        wait_tick(0, 4'hF, n);
        check("default first tick", 32'(n), 32'd256);
        check("default all ticks", 32'(tick), 32'hF);
        check("default clk rise", 32'(clk_out[0]), 32'd1);
        step(1'b0, 4'hF, 4'h0, 32'h0);
        check("default tick width", 32'(tick), 32'h0);
        wait_tick(0, 4'hF, n);
        check("default second tick", 32'(n), 32'd255);
        check("default clk fall", 32'(clk_out[0]), 32'd0);

        // Programmed ratios and a mid-period reload, vector by vector
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].sc, tbl[k].en, tbl[k].ld, tbl[k].dv);
            check($sformatf("tbl%0d tick", k), 32'(tick), 32'(tbl[k].t));
            check($sformatf("tbl%0d clk_out", k), 32'(clk_out), 32'(tbl[k].c));
            check($sformatf("tbl%0d pending", k), 32'(pending), 32'(tbl[k].p));
        end
        wait_tick(2, 4'hF, n);
        check("reload ch2 first", 32'(n), 32'd6);
        wait_tick(2, 4'hF, n);
        check("reload ch2 spacing a", 32'(n), 32'd8);
        wait_tick(2, 4'hF, n);
        check("reload ch2 spacing b", 32'(n), 32'd8);

        // Load coincident with a wrap on ch1
        step(1'b1, 4'hF, 4'b0010, divs(0, 1, 0, 0));
        step(1'b0, 4'hF, 4'h0, 32'h0);
        step(1'b0, 4'hF, 4'b0010, divs(0, 4, 0, 0));
        check("coincide tick", 32'(tick[1]), 32'd1);
        check("coincide pending", 32'(pending[1]), 32'd1);
        wait_tick(1, 4'hF, n);
        check("coincide old spacing", 32'(n), 32'd2);
        wait_tick(1, 4'hF, n);
        check("coincide new spacing a", 32'(n), 32'd5);
        wait_tick(1, 4'hF, n);
        check("coincide new spacing b", 32'(n), 32'd5);

        // Disable ch3 at counter 5 for 20 cycles, then resume without phase loss
        step(1'b1, 4'hF, 4'b1000, divs(0, 0, 0, 9));
        for (int k = 0; k < 5; k++) step(1'b0, 4'hF, 4'h0, 32'h0);
        held = clk_out[3];
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0111, 4'h0, 32'h0);
            check("disabled tick", 32'(tick[3]), 32'd0);
            check("disabled clk_out", 32'(clk_out[3]), 32'(held));
        end
        wait_tick(3, 4'hF, n);
        check("resume spacing", 32'(n), 32'd5);

        // Staggered channels realigned by sync_clear with equal ratios
        step(1'b1, 4'hF, 4'hF, divs(5, 5, 5, 5));
        check("clear clk_out", 32'(clk_out), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 4'hF, 4'h0, 32'h0);
            check($sformatf("aligned tick %0d", k), 32'(tick), (k == 6) ? 32'hF : 32'h0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic          s;
            logic [CH-1:0] e, l;
            logic [31:0]   d;
            s = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < CH; i++) begin
                e[i] = ($urandom_range(0, 9) != 0);
                l[i] = ($urandom_range(0, 19) == 0);
            end
            d = divs($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12));
            step(s, e, l, d);
        end

        // Asynchronous reset mid-count, then the default ratio must be back
        #2 reset = 1'b1;
        #1;
        check("async reset tick", 32'(tick), 32'h0);
        check("async reset clk_out", 32'(clk_out), 32'h0);
        check("async reset pending", 32'(pending), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_tick(0, 4'hF, n);
        check("post reset period", 32'(n), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
